// File: rtl/pwm_bank.sv
// Bank of PWM channels sharing one prescaler and period counter.
// Period, prescaler and duty are double-buffered; the rest is live.
module pwm_bank #(
  parameter int StartAddress = 0,
  parameter int AddressWidth = 8,
  parameter int BitWidth     = 8,
  parameter int NumChannels  = 4
) (
  input  logic                    CLK,
  input  logic                    _RST,
  input  logic                    _Write,
  input  logic [AddressWidth-1:0] AddressBus,
  input  logic [BitWidth-1:0]     DataIn,
  output logic [NumChannels-1:0]  PWMOut,
  output logic                    PeriodEnd
);

  localparam int RegCount = 7 + 2 * NumChannels;

  typedef logic [AddressWidth:0] off_t;
  typedef enum logic {DirUp, DirDown} dir_t;

  off_t off;
  logic in_map;
  logic wr;

  logic [15:0] prd_buf, psc_buf;
  logic [15:0] prd_act, psc_act;
  logic [15:0] duty_buf [NumChannels];
  logic [15:0] duty_act [NumChannels];

  logic run, center;
  logic [NumChannels-1:0] en, pol;

  logic [15:0] pcnt_q, pcnt_d;
  logic [15:0] cnt_q, cnt_d;
  dir_t dir_q, dir_d;
  logic tick, boundary, load;
  logic [NumChannels-1:0] raw;

  // Extra top bit catches addresses below the base.
  assign off = {1'b0, AddressBus} - off_t'(StartAddress);
  assign in_map = !off[AddressWidth] &&
                  (off < off_t'(RegCount));
  assign wr = !_Write && in_map;

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      prd_buf <= '0;
      psc_buf <= '0;
      run     <= 1'b0;
      center  <= 1'b0;
      en      <= '0;
      pol     <= '0;
      for (int k = 0; k < NumChannels; k++)
        duty_buf[k] <= '0;
    end else if (wr) begin
      unique case (1'b1)
        off == off_t'(0): prd_buf[15:8] <= DataIn;
        off == off_t'(1): prd_buf[7:0]  <= DataIn;
        off == off_t'(2): psc_buf[15:8] <= DataIn;
        off == off_t'(3): psc_buf[7:0]  <= DataIn;
        off == off_t'(4): begin
          run    <= DataIn[0];
          center <= DataIn[1];
        end
        off == off_t'(5): en  <= DataIn[NumChannels-1:0];
        off == off_t'(6): pol <= DataIn[NumChannels-1:0];
        default: ;
      endcase
      for (int k = 0; k < NumChannels; k++) begin
        if (off == off_t'(7 + 2 * k))
          duty_buf[k][15:8] <= DataIn;
        if (off == off_t'(8 + 2 * k))
          duty_buf[k][7:0] <= DataIn;
      end
    end
  end

  always_comb begin
    tick     = run && (pcnt_q == psc_act);
    pcnt_d   = pcnt_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (!run) begin
      pcnt_d = '0;
      cnt_d  = '0;
      dir_d  = DirUp;
    end else begin
      pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
      if (!center)
        dir_d = DirUp;
      if (tick) begin
        if (!center) begin
          if (cnt_q >= prd_act) begin
            cnt_d    = '0;
            boundary = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          // Endpoints hold for two ticks: the turn costs a tick.
          unique case (dir_q)
            DirUp: begin
              if (cnt_q >= prd_act)
                dir_d = DirDown;
              else
                cnt_d = cnt_q + 16'd1;
            end
            DirDown: begin
              if (cnt_q == 16'd0) begin
                dir_d    = DirUp;
                boundary = 1'b1;
              end else begin
                cnt_d = cnt_q - 16'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign load = !run || boundary;

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      pcnt_q <= '0;
      cnt_q  <= '0;
      dir_q  <= DirUp;
    end else begin
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
    end
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      prd_act <= '0;
      psc_act <= '0;
      for (int k = 0; k < NumChannels; k++)
        duty_act[k] <= '0;
    end else if (load) begin
      prd_act <= prd_buf;
      psc_act <= psc_buf;
      for (int k = 0; k < NumChannels; k++)
        duty_act[k] <= duty_buf[k];
    end
  end

  always_comb begin
    raw = '0;
    for (int k = 0; k < NumChannels; k++)
      raw[k] = cnt_q < duty_act[k];
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      PWMOut    <= '0;
      PeriodEnd <= 1'b0;
    end else begin
      PWMOut    <= ({NumChannels{run}} & en & raw) ^ pol;
      PeriodEnd <= boundary;
    end
  end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter StartAddress, default 0, base bus address of the register map.
REQ-002 SHALL have parameter AddressWidth, default 8, width of AddressBus.
REQ-003 SHALL have parameter BitWidth, default 8, width of DataIn; only 8 is supported.
REQ-004 SHALL have parameter NumChannels, default 4, number of PWM outputs; legal range 1..8.
REQ-005 SHALL have port CLK, input, 1, the single system clock; all state changes on its rising edge except reset.
REQ-006 SHALL have port _RST, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port _Write, input, 1, active-low write strobe, sampled on CLK.
REQ-008 SHALL have port AddressBus, input, AddressWidth, register address.
REQ-009 SHALL have port DataIn, input, BitWidth, write data.
REQ-010 SHALL have port PWMOut, output, NumChannels, PWM outputs.
REQ-011 SHALL have port PeriodEnd, output, 1, one-CLK pulse at each period boundary.

Function
REQ-012 SHALL perform a write on each CLK edge where _Write=0 and AddressBus is in the map; out-of-map writes are ignored.
REQ-013 Register map, offsets from StartAddress: 0/1 Period hi/lo; 2/3 Prescaler hi/lo; 4 Control (bit0 Run, bit1 Center; other bits read-as-ignored); 5 Enable mask; 6 Polarity mask; 7+2k/8+2k Duty[k] hi/lo for k=0..NumChannels-1.
REQ-014 Period, Prescaler and Duty[k] SHALL each be a 16-bit buffer register plus a 16-bit active register; comparators use active values only.
REQ-015 Control, Enable and Polarity SHALL take effect on the CLK after the write (no shadowing).
REQ-016 Prescaler counter SHALL increment every CLK while Run=1; when it equals active Prescaler it clears to 0 and issues one tick (tick rate = CLK/(Prescaler+1)).
REQ-017 Edge mode (Center=0): period counter counts 0..Period on ticks, wraps to 0; period = Period+1 ticks.
REQ-018 Center mode (Center=1): counter counts up 0..Period then down Period..0, each endpoint held two ticks; period = 2*(Period+1) ticks; direction flag resets to up.
REQ-019 Boundary SHALL be the tick on which the counter returns to 0 (edge wrap, or center down-phase leaving 0); on that CLK PeriodEnd=1 and all active registers load from buffers.
REQ-020 A buffer write in the same CLK as a boundary SHALL NOT reach active that boundary; it loads at the next boundary.
REQ-021 Channel k raw level SHALL be 1 when counter < active Duty[k]; Duty=0 gives constant 0, Duty>=Period+1 gives constant 1 (16-bit unsigned compare, no overflow).
REQ-022 PWMOut[k] SHALL be registered: PWMOut[k] = (Enable[k] & Run & raw) XOR Polarity[k], one CLK after the counter value it reflects.
REQ-023 Disabled channel or Run=0 SHALL drive PWMOut[k]=Polarity[k] (idle level).
REQ-024 While Run=0: prescaler counter, period counter and direction held at 0/up, active registers load from buffers every CLK, PeriodEnd=0.
REQ-025 Run 0->1 SHALL start counting from 0 on the next CLK; Run 1->0 SHALL clear counters on the next CLK.
REQ-026 Changing Center while running SHALL take effect at once with counter unchanged and direction up.

Reset
REQ-027 _RST=0 SHALL immediately clear all buffer, active, Control, Enable, Polarity registers, both counters, direction (up), PWMOut (all 0) and PeriodEnd (0), independent of CLK.
REQ-028 Reset mid-period SHALL abort the period; after release block is idle until Run is written.

Verification
REQ-029 Edge: Prescaler=0, Period=9, Duty[0]=3, Enable=1, Run=1 -> PWMOut[0] high 3 of every 10 CLKs, PeriodEnd every 10 CLKs.
REQ-030 Bounds: Duty[0]=0 -> PWMOut[0] constant 0; Duty[0]=10 (Period=9) -> constant 1; Polarity[0]=1 inverts both.
REQ-031 Shadow: Duty[0] 3->7 written mid-period -> current period keeps 3 high CLKs, next period 7; write coincident with PeriodEnd applies one period later.
REQ-032 Center: Prescaler=1, Period=4, Duty[1]=2, Center=1 -> period 20 CLKs, PWMOut[1] high 8 CLKs centred on boundary.
REQ-033 Multi-channel: NumChannels=4, Duty={0,5,10,20}, Period=19, Enable=0b1011 -> high counts {0,5,-,20} per 20 CLKs, PWMOut[2]=Polarity[2].
REQ-034 Reset: assert _RST mid-period with Run=1 -> PWMOut=0, PeriodEnd=0 without a CLK edge; after release no toggling until Run=1 rewritten.
